// File: rtl/instruction_loader.sv
// Serial boot loader: receives a length-prefixed, XOR-checksummed byte stream and
// writes it as big-endian 32-bit words into instruction memory while holding the CPU.
module instruction_loader #(
    parameter logic [11:0] BASE_ADDR = 12'h000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        im_cs,
    output logic        im_wr,
    output logic        im_rd,
    output logic [11:0] im_addr,
    output logic [31:0] im_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE, ERR} state_t;

    state_t      state_reg, state_next;
    logic [15:0] count_reg;
    logic [15:0] word_index_reg;
    logic [7:0]  checksum_reg;
    logic [23:0] shift_reg;
    logic [1:0]  byte_cnt_reg;
    logic        xfer;
    logic [15:0] len_full;

    assign xfer     = byte_valid && byte_ready;
    assign len_full = {count_reg[15:8], byte_in};
    assign im_rd    = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE, ERR: if (start) state_next = LEN_HI;
            LEN_HI:          if (xfer) state_next = LEN_LO;
            LEN_LO: begin
                if (xfer) begin
                    if (32'(len_full) > MAX_WORDS) state_next = ERR;
                    else if (len_full == 16'd0)    state_next = CHECK;
                    else                           state_next = DATA;
                end
            end
            DATA:   if (xfer && byte_cnt_reg == 2'd3) state_next = WRITE;
            WRITE:  state_next = (word_index_reg + 16'd1 == count_reg) ? CHECK : DATA;
            CHECK:  if (xfer) state_next = (byte_in == checksum_reg) ? DONE : ERR;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        im_cs      = 1'b0;
        im_wr      = 1'b0;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (state_reg)
            LEN_HI, LEN_LO, DATA, CHECK: byte_ready = 1'b1;
            WRITE: begin
                im_cs = 1'b1;
                im_wr = 1'b1;
            end
            IDLE:    cpu_hold = 1'b0;
            DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            ERR:     error = 1'b1;
            default: ;
        endcase
    end

    // Address and data are latched on the 4th payload byte so they are stable for
    // the whole WRITE cycle and simply hold afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg      <= '0;
            word_index_reg <= '0;
            checksum_reg   <= '0;
            shift_reg      <= '0;
            byte_cnt_reg   <= '0;
            im_addr        <= '0;
            im_data        <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        word_index_reg <= '0;
                        checksum_reg   <= '0;
                        byte_cnt_reg   <= '0;
                    end
                end
                LEN_HI: if (xfer) count_reg[15:8] <= byte_in;
                LEN_LO: if (xfer) count_reg[7:0]  <= byte_in;
                DATA: begin
                    if (xfer) begin
                        checksum_reg <= checksum_reg ^ byte_in;
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        shift_reg    <= {shift_reg[15:0], byte_in};
                        if (byte_cnt_reg == 2'd3) begin
                            im_data <= {shift_reg, byte_in};
                            im_addr <= BASE_ADDR + {word_index_reg[9:0], 2'b00};
                        end
                    end
                end
                WRITE:   word_index_reg <= word_index_reg + 16'd1;
                default: ;
            endcase
        end
    end

endmodule
